// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing-LED controller: one shared PWM counter and step prescaler
// drive CH channels, each in OFF, ON, BREATHE (triangle ramp) or BLINK mode.
module breath_pwm_multi #(
    parameter int CH       = 4,
    parameter int PWM_W    = 8,
    parameter int STEP_DIV = 1024
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic            sync,
    input  logic [2*CH-1:0] mode,
    output logic [CH-1:0]   pwm,
    output logic            step_tick
);

    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_W-1:0] MAX       = '1;
    localparam logic [PWM_W:0]   FULL      = {1'b1, {PWM_W{1'b0}}};
    localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_t;

    logic [PWM_W-1:0] pwm_cnt;
    logic [SW-1:0]    step_cnt;
    logic             wrap;
    logic             tick;

    assign wrap = en && (pwm_cnt == MAX);
    assign tick = wrap && (step_cnt == STEP_LAST);

    // Shared timebase; wrap and tick already include en, so en=0 freezes everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt   <= '0;
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (sync) begin
            pwm_cnt   <= '0;
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= tick;
            if (en) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (wrap) begin
                step_cnt <= tick ? '0 : step_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        localparam logic [PWM_W-1:0] LVL_INIT = PWM_W'((i * (2 ** PWM_W)) / CH);

        mode_t            ch_mode;
        logic [PWM_W-1:0] lvl;
        logic [PWM_W-1:0] lvl_nxt;
        logic             dir;
        logic             dir_nxt;
        logic [PWM_W:0]   duty_q;
        logic [PWM_W:0]   duty_nxt;
        logic             pwm_q;

        assign ch_mode = mode_t'(mode[2*i +: 2]);
        assign pwm[i]  = pwm_q;

        // Triangle ramp; each end dwells for one step while the direction flips.
        always_comb begin
            lvl_nxt = lvl;
            dir_nxt = dir;
            if (dir) begin
                if (lvl == MAX) begin
                    dir_nxt = 1'b0;
                end else begin
                    lvl_nxt = lvl + 1'b1;
                end
            end else begin
                if (lvl == '0) begin
                    dir_nxt = 1'b1;
                end else begin
                    lvl_nxt = lvl - 1'b1;
                end
            end
        end

        always_comb begin
            duty_nxt = '0;
            case (ch_mode)
                MODE_OFF:     duty_nxt = '0;
                MODE_ON:      duty_nxt = FULL;
                MODE_BREATHE: duty_nxt = {1'b0, lvl};
                MODE_BLINK:   duty_nxt = dir ? FULL : '0;
            endcase
        end

        // Duty is only reloaded at a period boundary so a period is never cut short.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                lvl    <= LVL_INIT;
                dir    <= 1'b1;
                duty_q <= '0;
                pwm_q  <= 1'b0;
            end else if (sync) begin
                lvl    <= LVL_INIT;
                dir    <= 1'b1;
                duty_q <= '0;
                pwm_q  <= 1'b0;
            end else begin
                if (tick) begin
                    lvl <= lvl_nxt;
                    dir <= dir_nxt;
                end
                if (wrap) begin
                    duty_q <= duty_nxt;
                end
                pwm_q <= en && ({1'b0, pwm_cnt} < duty_q);
            end
        end
    end

endmodule

// File: tb/tb_breath_pwm_multi.sv
// Bench for breath_pwm_multi: a cycle model built on elapsed enabled time feeds an
// expectation queue, plus directed per-period high-count and tick-timing checks.
module tb_breath_pwm_multi;

    localparam int CH       = 4;
    localparam int PW       = 4;
    localparam int SD       = 2;
    localparam int PERIOD   = 1 << PW;
    localparam int TICK_LEN = PERIOD * SD;
    localparam int NPOS     = 2 * PERIOD;
    localparam int FULL     = PERIOD;
    localparam int NPER     = 64;

    localparam logic [2*CH-1:0] MODE_ALL_OFF = 8'b00_00_00_00;
    localparam logic [2*CH-1:0] MODE_MIX     = 8'b10_11_10_01;
    localparam logic [2*CH-1:0] MODE_MIX_C0  = 8'b10_11_10_00;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en;
    logic            sync;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   pwm;
    logic            step_tick;

    int tests_run    = 0;
    int tests_failed = 0;

    int           model_t;
    int           model_duty[CH];
    logic [CH:0]  exp_q[$];

    int hi[CH][NPER];
    int sample_idx;
    int ticks_seen;
    int first_tick;

    always #5 clk = ~clk;

    breath_pwm_multi #(
        .CH(CH),
        .PWM_W(PW),
        .STEP_DIV(SD)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .sync(sync),
        .mode(mode),
        .pwm(pwm),
        .step_tick(step_tick)
    );

    function automatic int start_lvl(input int i);
        return (i * FULL) / CH;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic start_window();
        foreach (hi[i, j]) hi[i][j] = 0;
        sample_idx = 0;
        ticks_seen = 0;
        first_tick = -1;
    endtask

    function automatic int window_total();
        int s = 0;
        foreach (hi[i, j]) s += hi[i][j];
        return s;
    endfunction

    // Brightness position on a 2*PERIOD cycle: first half ramps up, second half down.
    task automatic model_edge(input logic e, input logic s, input logic [2*CH-1:0] m);
        logic [CH-1:0] ep;
        logic          et;
        int            cnt, pos, lvl;
        ep = '0;
        et = 1'b0;
        if (s) begin
            model_t = 0;
            foreach (model_duty[i]) model_duty[i] = 0;
        end else if (e) begin
            cnt = model_t % PERIOD;
            for (int i = 0; i < CH; i++) ep[i] = (cnt < model_duty[i]);
            et = ((model_t % TICK_LEN) == TICK_LEN - 1);
            if (cnt == PERIOD - 1) begin
                for (int i = 0; i < CH; i++) begin
                    pos = (start_lvl(i) + model_t / TICK_LEN) % NPOS;
                    lvl = (pos < PERIOD) ? pos : NPOS - 1 - pos;
                    case (m[2*i +: 2])
                        2'b00:   model_duty[i] = 0;
                        2'b01:   model_duty[i] = FULL;
                        2'b10:   model_duty[i] = lvl;
                        default: model_duty[i] = (pos < PERIOD) ? FULL : 0;
                    endcase
                end
            end
            model_t++;
        end
        exp_q.push_back({ep, et});
    endtask

    task automatic checkOutput();
        logic [CH:0] exp_v;
        int          p;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            exp_v = exp_q.pop_front();
            check("pwm", pwm, exp_v[CH:1]);
            check("step_tick", step_tick, exp_v[0]);
        end
        sample_idx++;
        p = (sample_idx - 1) / PERIOD + 1;
        if (p < NPER) begin
            for (int i = 0; i < CH; i++) hi[i][p] += int'(pwm[i]);
        end
        if (step_tick === 1'b1) begin
            ticks_seen++;
            if (first_tick < 0) first_tick = sample_idx;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic s, input logic [2*CH-1:0] m);
        en   = e;
        sync = s;
        mode = m;
        @(posedge clk);
        model_edge(e, s, m);
        #1;
        checkOutput();
    endtask

    task automatic run_edges(input int n, input logic e, input logic [2*CH-1:0] m);
        for (int k = 0; k < n; k++) applyStimulus(e, 1'b0, m);
    endtask

    task automatic do_reset(input logic [2*CH-1:0] m);
        rstn = 1'b0;
        en   = 1'b1;
        sync = 1'b0;
        mode = m;
        #2;
        check("reset_pwm", pwm, 0);
        check("reset_tick", step_tick, 0);
        model_t = 0;
        foreach (model_duty[i]) model_duty[i] = 0;
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        start_window();
    endtask

    initial begin
        rstn = 1'b1;
        en   = 1'b0;
        sync = 1'b0;
        mode = MODE_ALL_OFF;
        #3;

        // All channels off: outputs stay low, tick every 32 clocks.
        do_reset(MODE_ALL_OFF);
        run_edges(64, 1'b1, MODE_ALL_OFF);
        check("off_ticks", ticks_seen, 2);
        check("off_first_tick", first_tick, 32);
        check("off_high_total", window_total(), 0);

        // Mixed modes from reset: ON, BREATHE(4), BLINK(8), BREATHE(12).
        do_reset(MODE_MIX);
        run_edges(52 * PERIOD, 1'b1, MODE_MIX);
        check("on_p1", hi[0][1], 0);
        check("on_p2", hi[0][2], 16);
        check("on_p51", hi[0][51], 16);
        check("br1_p2", hi[1][2], 4);
        check("br1_p3", hi[1][3], 4);
        check("br1_p4", hi[1][4], 5);
        check("br3_p2", hi[3][2], 12);
        check("br3_p8", hi[3][8], 15);
        check("br3_p10", hi[3][10], 15);
        check("br3_p40", hi[3][40], 0);
        check("br3_p42", hi[3][42], 0);
        check("br3_p44", hi[3][44], 1);
        check("blk_p2", hi[2][2], 16);
        check("blk_p16", hi[2][16], 16);
        check("blk_p18", hi[2][18], 0);
        check("blk_p48", hi[2][48], 0);
        check("blk_p50", hi[2][50], 16);
        check("mix_ticks", ticks_seen, 26);

        // Asynchronous reset mid-ramp while ch0 is driving high.
        check("pre_reset_on", pwm[0], 1);
        do_reset(MODE_MIX);
        run_edges(4 * PERIOD, 1'b1, MODE_MIX);
        check("rst_on_p1", hi[0][1], 0);
        check("rst_br1_p2", hi[1][2], 4);
        check("rst_br3_p2", hi[3][2], 12);

        // Sync pulse mid-ramp realigns counters and levels.
        run_edges(36, 1'b1, MODE_MIX);
        applyStimulus(1'b1, 1'b1, MODE_MIX);
        check("sync_pwm", pwm, 0);
        start_window();
        run_edges(4 * PERIOD, 1'b1, MODE_MIX);
        check("sync_br1_p2", hi[1][2], 4);
        check("sync_br3_p2", hi[3][2], 12);
        check("sync_blk_p2", hi[2][2], 16);
        check("sync_first_tick", first_tick, 32);

        // Hold en low for 100 clocks, then resume from the held counters.
        run_edges(8, 1'b1, MODE_MIX);
        start_window();
        run_edges(100, 1'b0, MODE_MIX);
        check("en_off_ticks", ticks_seen, 0);
        check("en_off_high", window_total(), 0);
        start_window();
        run_edges(30, 1'b1, MODE_MIX);
        check("resume_first_tick", first_tick, 24);

        // ch0 switched OFF mid-period keeps its full duty until the boundary.
        applyStimulus(1'b1, 1'b0, MODE_MIX_C0);
        check("midperiod_hold", pwm[0], 1);
        run_edges(17, 1'b1, MODE_MIX_C0);
        check("after_boundary", pwm[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/breath_pwm_multi.md
Name: breath_pwm_multi

Overview:
Multi-channel breathing-LED controller, parametrised in channel count, PWM resolution and breath speed. One shared PWM counter and step prescaler drive CH independent channels. Each channel has a runtime mode: off, on, breathe (triangle brightness ramp) or blink. At reset the channels start phase-staggered. Sits between board-level control logic and the LED pins.

Parameters:
CH, 4, number of LED channels (>=1)
PWM_W, 8, PWM counter and brightness width; PWM period = 2^PWM_W clocks; MAX = 2^PWM_W-1
STEP_DIV, 1024, PWM periods per brightness step (>=1)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
en  input  1  global enable; 0 freezes all counters and forces all outputs to 0
sync  input  1  single-cycle realign pulse
mode  input  2*CH  per-channel mode; bits [2i+1:2i] for channel i: 00 OFF, 01 ON, 10 BREATHE, 11 BLINK
pwm  output  CH  registered PWM outputs, one per LED
step_tick  output  1  registered one-cycle pulse per brightness step

Behaviour:
- Reset (async, rstn=0): pwm_cnt=0, step_cnt=0, pwm=0, step_tick=0, all duty_q=0.
  - Channel i reset state: lvl_i = (i*2^PWM_W)/CH (truncated), dir_i = up.
- pwm_cnt: PWM_W bits, increments every cycle while en=1, wraps MAX->0.
- wrap is asserted when pwm_cnt==MAX and en=1.
- step_cnt: counts 0..STEP_DIV-1 on each wrap.
- tick is asserted when wrap=1 and step_cnt==STEP_DIV-1. On that edge:
  - step_cnt returns to 0.
  - step_tick<=1 for exactly one cycle; step_tick is 0 on all other cycles.
- Level update on a tick edge, every channel, in all modes:
  - dir up, lvl<MAX: lvl+1.
  - dir up, lvl==MAX: dir<=down, lvl holds (one-step dwell).
  - dir down, lvl>0: lvl-1.
  - dir down, lvl==0: dir<=up, lvl holds.
  - Breath period = 2^(PWM_W+1) steps.
- Duty latch: duty_q_i is PWM_W+1 bits and is loaded on every wrap edge from pre-edge mode and lvl/dir:
  - OFF: 0.
  - ON: 2^PWM_W.
  - BREATHE: lvl_i.
  - BLINK: dir_i ? 2^PWM_W : 0.
  - A mode or level change therefore takes effect only at a PWM period boundary, so no glitches occur mid-period.
  - A level changed on a tick edge appears in duty one PWM period later.
- Output: pwm_i <= en & (pwm_cnt < duty_q_i), registered, one-cycle latency from pwm_cnt.
  - duty 2^PWM_W gives a constant 1; duty 0 gives a constant 0.
- en=0: pwm_cnt, step_cnt, lvl, dir and duty_q hold; pwm<=0; step_tick<=0. Operation resumes seamlessly when en returns to 1.
- sync=1 (priority over en and tick, regardless of en): pwm_cnt=0, step_cnt=0, duty_q=0, step_tick=0; every lvl/dir returns to its reset stagger state; pwm<=0.
- Asserting rstn mid-ramp aborts immediately to the reset state; no partial state survives.

Test Plan:
All tests use CH=4, PWM_W=4, STEP_DIV=2 (16-clk period, tick every 32 clks, breath period 32 steps), en=1.
1. Release reset, mode=all OFF -> pwm=0000 and step_tick=0 throughout; step_tick pulses once every 32 clks, the first on the edge ending cycle 31.
2. ch0 mode ON from reset -> pwm[0]=0 for the first period; from the cycle after the first wrap (pwm_cnt=0 of period 2, output visible one clock later) pwm[0] is constantly 1.
3. ch1 BREATHE (lvl starts 4) -> period 2 duty = 4/16 high; after the first tick lvl=5, and duty 5/16 appears one period later.
4. ch3 BREATHE (start 12) -> lvl sequence per tick 13, 14, 15, 15 (dwell, dir down), 14 ... 0, 0, 1; high counts per period track lvl.
5. ch2 BLINK (start lvl 8, dir up) -> pwm[2] is 1 for 8 steps, reverses at MAX, 0 for 16 steps, 1 for 16 steps, repeating.
6. Mid-ramp: pulse sync -> next cycle pwm=0000 and pwm_cnt=0, and levels return to 0/4/8/12. Separately, hold en=0 for 100 clks -> pwm=0 and step_tick=0; on en=1 the counters resume from their held values.
